// File: rtl/stopwatch_seq_ctrl.sv
`default_nettype none
// =============================================================================
// stopwatch_seq_ctrl : 00-59 BCD stopwatch, button FSM, prescaler, muxed 7-seg
// Revision 1.0
// =============================================================================
module stopwatch_seq_ctrl #(
  parameter int SCAN_W = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn;
  logic [2:0] sel;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign btn   = io_in[4:2];
  assign sel   = io_in[7:5];

  // Button order in these vectors: [0]=start, [1]=lap, [2]=clear
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] sync3_q, sync3_d;
  logic [2:0] rise;
  logic       start_ev;
  logic       lap_ev;
  logic       clr_ev;

  state_t            state_q, state_d;
  logic [3:0]        units_q, units_d;
  logic [2:0]        tens_q, tens_d;
  logic [3:0]        lap_units_q, lap_units_d;
  logic [2:0]        lap_tens_q, lap_tens_d;
  logic [6:0]        pre_q, pre_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              dsel_q, dsel_d;

  logic       lap_cap;
  logic       clear_all;
  logic       running;
  logic       tick;
  logic [7:0] limit;
  logic [3:0] shown_units;
  logic [2:0] shown_tens;
  logic [3:0] digit;
  logic [6:0] seg;

  assign sync1_d  = btn;
  assign sync2_d  = sync1_q;
  assign sync3_d  = sync2_q;
  assign rise     = sync2_q & ~sync3_q;
  assign start_ev = rise[0];
  assign lap_ev   = rise[1];
  assign clr_ev   = rise[2];

  always_comb begin
    state_d   = state_q;
    lap_cap   = 1'b0;
    clear_all = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) state_d = RUN;
      end
      RUN: begin
        if (start_ev) begin
          state_d = PAUSE;
        end else if (lap_ev) begin
          state_d = LAP;
          lap_cap = 1'b1;
        end
      end
      LAP: begin
        if (start_ev)    state_d = PAUSE;
        else if (lap_ev) state_d = RUN;
      end
      PAUSE: begin
        // Clear outranks start when both arrive on the same edge
        if (clr_ev) begin
          state_d   = IDLE;
          clear_all = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick period is 2^sel clocks; >= compare makes a lowered sel tick at once
  assign running = (state_q == RUN) || (state_q == LAP);
  assign limit   = (8'd1 << sel) - 8'd1;
  assign tick    = running && (pre_q >= limit[6:0]);

  always_comb begin
    pre_d = pre_q;
    if (clear_all || (state_q == IDLE)) begin
      pre_d = 7'd0;
    end else if (running) begin
      pre_d = tick ? 7'd0 : pre_q + 7'd1;
    end
  end

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (clear_all) begin
      units_d = 4'd0;
      tens_d  = 3'd0;
    end else if (tick) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = (tens_q == 3'd5) ? 3'd0 : tens_q + 3'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_comb begin
    lap_units_d = lap_units_q;
    lap_tens_d  = lap_tens_q;
    if (lap_cap) begin
      lap_units_d = units_q;
      lap_tens_d  = tens_q;
    end
  end

  assign scan_d = scan_q + SCAN_W'(1);
  assign dsel_d = (&scan_q) ? ~dsel_q : dsel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 3'd0;
      sync2_q     <= 3'd0;
      sync3_q     <= 3'd0;
      state_q     <= IDLE;
      units_q     <= 4'd0;
      tens_q      <= 3'd0;
      lap_units_q <= 4'd0;
      lap_tens_q  <= 3'd0;
      pre_q       <= 7'd0;
      scan_q      <= '0;
      dsel_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      state_q     <= state_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      lap_units_q <= lap_units_d;
      lap_tens_q  <= lap_tens_d;
      pre_q       <= pre_d;
      scan_q      <= scan_d;
      dsel_q      <= dsel_d;
    end
  end

  // Display path is decoded purely from flops so the pins never glitch on inputs
  assign shown_units = (state_q == LAP) ? lap_units_q : units_q;
  assign shown_tens  = (state_q == LAP) ? lap_tens_q  : tens_q;
  assign digit       = dsel_q ? {1'b0, shown_tens} : shown_units;

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

  assign io_out = {dsel_q, seg};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_seq_ctrl.sv
`default_nettype none
// =============================================================================
// tb_stopwatch_seq_ctrl : directed + random bench against a seconds-level model
// Revision 1.0
// =============================================================================
module tb_stopwatch_seq_ctrl;

  localparam int SCAN_W = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  localparam logic [6:0] SEG_TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk;
  logic       rst_n;
  logic       start_b, lap_b, clr_b;
  logic [2:0] sel;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {sel, clr_b, lap_b, start_b, rst_n, clk};

  stopwatch_seq_ctrl #(.SCAN_W(SCAN_W)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: whole seconds, mode name, clocks since reset; buttons act two edges late
  int       m_mode, m_cnt, m_lap, m_pre, m_cyc;
  bit [2:0] h0, h1, h2;

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_lap = 0; m_pre = 0; m_cyc = 0;
    h0 = 3'b0; h1 = 3'b0; h2 = 3'b0;
  endtask

  task automatic model_step();
    bit [2:0] ev;
    bit       tick;
    int       old_cnt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = {clr_b, lap_b, start_b};
    tick = 1'b0;
    old_cnt = m_cnt;
    if (m_mode == M_RUN || m_mode == M_LAP) begin
      if (m_pre >= (1 << sel) - 1) begin tick = 1'b1; m_pre = 0; end
      else m_pre = m_pre + 1;
    end else if (m_mode == M_IDLE) begin
      m_pre = 0;
    end
    if (tick) m_cnt = (m_cnt + 1) % 60;
    case (m_mode)
      M_IDLE:  if (ev[0]) m_mode = M_RUN;
      M_RUN:   if (ev[0]) m_mode = M_PAUSE;
               else if (ev[1]) begin m_mode = M_LAP; m_lap = old_cnt; end
      M_LAP:   if (ev[0]) m_mode = M_PAUSE;
               else if (ev[1]) m_mode = M_RUN;
      default: if (ev[2]) begin m_mode = M_IDLE; m_cnt = 0; m_pre = 0; end
               else if (ev[0]) m_mode = M_RUN;
    endcase
    m_cyc = m_cyc + 1;
  endtask

  function automatic bit m_dsel();
    return ((m_cyc >> SCAN_W) % 2) == 1;
  endfunction

  function automatic logic [7:0] exp_out();
    int shown, dig;
    shown = (m_mode == M_LAP) ? m_lap : m_cnt;
    dig   = m_dsel() ? shown / 10 : shown % 10;
    return {m_dsel(), SEG_TAB[dig]};
  endfunction

  task automatic check_eq(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bound(input int n, input int lim, input string tag);
    checks++;
    assert (n < lim) else begin
      errors++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, lim);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq(io_out, exp_out(), tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic press(input bit s, input bit l, input bit c, input string tag);
    start_b = s; lap_b = l; clr_b = c;
    cycle(tag);
    start_b = 1'b0; lap_b = 1'b0; clr_b = 1'b0;
  endtask

  // Idle shows 00, so the units phase must read exactly 0x3F
  task automatic check_idle_zero(input string tag);
    int n;
    n = 0;
    while (m_dsel() && n < 16) begin cycle(tag); n++; end
    check_bound(n, 16, {tag, "_bound"});
    check_eq(io_out, 8'h3F, tag);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_b = 1'b0; lap_b = 1'b0; clr_b = 1'b0; sel = 3'd0;
    model_reset();

    // Reset held with random buttons
    for (int i = 0; i < 3; i++) begin
      {clr_b, lap_b, start_b} = 3'($urandom);
      sel = 3'($urandom);
      @(posedge clk);
      model_step();
      #1 check_eq(io_out, 8'h3F, "rst_hold_edge");
      @(negedge clk);
      check_eq(io_out, 8'h3F, "rst_hold_mid");
    end
    rst_n = 1'b1; start_b = 1'b0; lap_b = 1'b0; clr_b = 1'b0; sel = 3'd0;
    cycles(16, "post_reset_scan");

    // Count and wrap at sel=0
    press(1, 0, 0, "start_sel0");
    for (int i = 0; i < 70; i++) begin
      cycle("count_wrap");
      if (m_cnt >= 50 && m_dsel()) check_eq({1'b0, io_out[6:0]}, 8'h6D, "tens_five");
    end
    press(1, 0, 0, "pause_a");
    cycles(2, "pause_a");
    press(0, 0, 1, "clear_a");
    cycles(4, "clear_a");
    check_idle_zero("idle_after_clear_a");

    // Pause hold and clear at sel=3
    sel = 3'd3;
    press(1, 0, 0, "start_sel3");
    cycles(80, "run_sel3");
    press(1, 0, 0, "pause_b");
    cycles(10, "pause_hold");
    press(0, 0, 1, "clear_b");
    cycles(3, "clear_b");
    check_idle_zero("idle_after_clear_b");

    // Clear during RUN must be ignored
    press(1, 0, 0, "start_c");
    cycles(20, "run_c");
    press(0, 0, 1, "clear_in_run");
    cycles(20, "run_after_clear");
    press(1, 0, 0, "pause_c");
    cycles(3, "pause_c");
    press(0, 0, 1, "clear_c");
    cycles(3, "clear_c");

    // Lap freeze at 07, then release back to live count
    sel = 3'd0;
    press(1, 0, 0, "start_lap");
    n = 0;
    while (m_cnt != 5 && n < 60) begin cycle("lap_wait"); n++; end
    check_bound(n, 60, "lap_wait_bound");
    press(0, 1, 0, "lap_press");
    cycles(7, "lap_frozen");
    for (int i = 0; i < 8; i++) begin
      cycle("lap_frozen_07");
      check_eq({1'b0, io_out[6:0]}, m_dsel() ? 8'h3F : 8'h07, "lap_shows_07");
    end
    press(0, 1, 0, "lap_release");
    cycles(10, "live_after_lap");

    // Simultaneous presses
    press(1, 1, 0, "start_lap_same");
    cycles(4, "pause_after_same");
    press(1, 0, 1, "clear_start_same");
    cycles(4, "idle_after_same");
    check_idle_zero("idle_after_same_zero");

    // Prescaler lowered mid-count
    sel = 3'd7;
    press(1, 0, 0, "start_sel7");
    n = 0;
    while (m_pre != 40 && n < 200) begin cycle("pre_wait"); n++; end
    check_bound(n, 200, "pre_wait_bound");
    sel = 3'd2;
    cycles(20, "sel_lowered");

    // Asynchronous reset during LAP
    press(0, 1, 0, "lap_before_reset");
    cycles(5, "lap_before_reset");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_eq(io_out, 8'h3F, "async_reset");
    cycle("in_reset");
    rst_n = 1'b1;
    cycles(8, "after_async_reset");

    // Random button traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 32 == 0) sel = 3'($urandom_range(0, 3));
      start_b = ($urandom_range(0, 5) == 0);
      lap_b   = ($urandom_range(0, 5) == 0);
      clr_b   = ($urandom_range(0, 5) == 0);
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_seq_ctrl.md
# stopwatch_seq_ctrl

Two-digit (00–59) stopwatch controller for a tiny-tapeout user slot. It sequences a BCD seconds counter through idle, run, pause and lap states from push-button inputs. A selectable prescaler paces the count. Output is time-multiplexed onto one seven-segment digit plus a digit-select line, using the same 8-in/8-out pin budget as the other user modules.

## Interface
- SCAN_W, default 2: digit-select toggles every 2^SCAN_W clocks.
- io_in[0]  in  1  clock; all flops rise-edge.
- io_in[1]  in  1  reset, asynchronous, active-low.
- io_in[2]  in  1  start_stop button, active-high.
- io_in[3]  in  1  lap button, active-high.
- io_in[4]  in  1  clear button, active-high.
- io_in[7:5]  in  3  prescale select `sel`; tick period = 2^sel clocks (1..128).
- io_out[6:0]  out  7  segments a..g (bit0=a), active-high.
- io_out[7]  out  1  digit select: 0 = units digit shown, 1 = tens digit shown.

## Operation
- **Button conditioning**
  - Each button goes through a 2-flop synchronizer, then a rising-edge detect (sync2 & ~sync3).
  - One press equals one event, regardless of how long the button is held.
- **States:** IDLE, RUN, PAUSE, LAP (2-bit encoding).
  - IDLE --start--> RUN.
  - RUN --start--> PAUSE.
  - RUN --lap--> LAP. On this transition the lap register captures the current count.
  - LAP --lap--> RUN. The display returns to the live count.
  - LAP --start--> PAUSE. The display returns to live.
  - PAUSE --start--> RUN.
  - PAUSE --clear--> IDLE. Count and prescaler are zeroed.
  - Clear is ignored in RUN, LAP and IDLE. Lap is ignored in IDLE and PAUSE.
- **Simultaneous events**
  - start + lap in RUN/LAP: start wins; lap is dropped.
  - clear + start in PAUSE: clear wins, next state IDLE.
- **Count:** two BCD digits, units 0–9 and tens 0–5.
  - Incremented by one on each tick while the current state is RUN or LAP. LAP keeps counting internally.
  - Units 9 → 0 carries into tens. 59 → 00 wraps silently; no flag is raised.
  - The increment is decided by the state before the edge. A tick on the same edge as a RUN→PAUSE transition still increments.
- **Prescaler:** 7-bit counter.
  - In RUN/LAP: tick when cnt >= 2^sel−1, then cnt←0; otherwise cnt+1.
  - Holds in PAUSE. Held at 0 in IDLE.
  - Lowering sel mid-count gives a tick on the next clock (>= compare). sel=0 ticks every clock.
- **Display**
  - Shown value is the lap register in LAP, otherwise the live count.
  - A free-running SCAN_W-bit scan counter plus a select flop drives io_out[7]; the flop toggles when the scan counter is all-ones.
  - io_out[6:0] is the combinational decode of the selected digit: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Digit values above 9 are unreachable; decode them to 00.

## Timing
- **Reset (io_in[1] low):** asynchronous; every flop clears immediately, without waiting for a clock.
  - State IDLE, count 00, lap 00, prescaler 0, scan 0, synchronizers 0.
  - io_out = 0x3F: units digit, showing "0".
  - Reset mid-RUN or mid-LAP discards count and lap.
- **Button latency:** a button first sampled high at edge k produces its state change at edge k+2. The state is visible after edge k+2.
- **Hold time:** a press shorter than one clock period may be missed; no minimum is guaranteed below 1 cycle.
- **Count visibility:** a count increment appears on io_out at the edge where the tick is consumed, the next time that digit is selected.
- **Scan rate:** io_out[7] has period 2·2^SCAN_W clocks: 8 clocks at the default SCAN_W=2.
- **Outputs:** glitch-free with respect to registered state. The segment decode is purely combinational from flops.

## Test plan
- **Reset:** hold io_in[1]=0 for 3 cycles with random buttons.
  - Required: io_out=0x3F throughout.
  - After release with no buttons: digits stay 00, io_out[7] toggles every 4 clocks.
- **Count and wrap:** sel=0, press start.
  - Required: state RUN 2 edges after press, then count +1 per clock.
  - After 60 ticks the count wraps 59→00; the tens digit reads 0x6D at 50–59.
- **Pause and clear:** sel=3, run 80 clocks from start (count 10), press start, then clear.
  - Required: count holds 10 in PAUSE; clear returns it to 00 and state to IDLE.
  - Clear pressed during RUN leaves count unchanged.
- **Lap:** sel=0, start; press lap at count 07; wait 5 ticks.
  - Required: display frozen at 07 while internal count reaches 12.
  - A second lap press makes the display show live 12+.
- **Simultaneous presses:** start+lap together in RUN gives PAUSE with lap unchanged. clear+start together in PAUSE gives IDLE.
- **Prescale change:** sel=7 with prescaler at 40, then switch sel to 2.
  - Required: tick on the next clock, then every 4 clocks.
- **Async reset:** assert reset mid-cycle during LAP.
  - Required: io_out=0x3F before the next clock edge.
